serial_subtractor: RTL and testbench

Bit-serial N-bit subtractor that computes A − B one bit per clock, LSB first. It wraps a single-bit full-subtractor cell, the one-bit half-subtractor extended with a borrow-in, together with a registered borrow flip-flop, operand shift registers and a start/done handshake. It is the sequential stage directly downstream of the half/full-subtractor cells. Parallel operands come in, and the result is registered out for the next datapath stage.

---
 rtl/serial_subtractor.sv | 124 ++++++++++++
 tb/tb_serial_subtractor.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (a - b), LSB first, one bit per clock, start/done handshake.
// Optional signed-overflow output is built when SERIAL_SUB_SIGNED_EN is defined.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_SIGNED_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic             br;
    logic [CW-1:0]    cnt;
    logic [WIDTH-2:0] pr;
    logic [WIDTH-1:0] pr_ext;
    logic             d_bit;
    logic             br_nxt;
    logic             accept;
    logic             last;
`ifdef SERIAL_SUB_SIGNED_EN
    logic             a_msb;
    logic             b_msb;
`endif

    // Single-bit full-subtractor cell: returns {borrow_out, difference}.
    function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bin);
        full_sub = {(~x & y) | (~(x ^ y) & bin), x ^ y ^ bin};
    endfunction

    assign {br_nxt, d_bit} = full_sub(sa[0], sb[0], br);
    assign pr_ext = {d_bit, pr};
    assign accept = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign last   = (state == ST_SHIFT) && (cnt == CNT_LAST);

    assign busy = (state == ST_SHIFT);
    assign done = (state == ST_DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_SHIFT;
            ST_SHIFT: if (cnt == CNT_LAST) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = start ? ST_SHIFT : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand capture and bit-serial shift; pr collects difference bits arriving at its MSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa  <= '0;
            sb  <= '0;
            br  <= 1'b0;
            cnt <= '0;
            pr  <= '0;
`ifdef SERIAL_SUB_SIGNED_EN
            a_msb <= 1'b0;
            b_msb <= 1'b0;
`endif
        end else if (accept) begin
            sa  <= a;
            sb  <= b;
            br  <= 1'b0;
            cnt <= '0;
            pr  <= '0;
`ifdef SERIAL_SUB_SIGNED_EN
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
`endif
        end else if (state == ST_SHIFT) begin
            sa  <= {1'b0, sa[WIDTH-1:1]};
            sb  <= {1'b0, sb[WIDTH-1:1]};
            br  <= br_nxt;
            cnt <= cnt + 1'b1;
            pr  <= pr_ext[WIDTH-1:1];
        end
    end

    // Result registers only change on the edge that processes the final bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            diff       <= '0;
            borrow_out <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_EN
            ovf        <= 1'b0;
`endif
        end else if (last) begin
            diff       <= pr_ext;
            borrow_out <= br_nxt;
`ifdef SERIAL_SUB_SIGNED_EN
            ovf        <= (a_msb != b_msb) && (d_bit != a_msb);
`endif
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: vector table plus multi-cycle handshake/reset sequences.
// Checks ovf as well when SERIAL_SUB_SIGNED_EN is defined.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
`ifdef SERIAL_SUB_SIGNED_EN
    logic         ovf;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
`ifdef SERIAL_SUB_SIGNED_EN
        ,
        .ovf        (ovf)
`endif
    );

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [W-1:0] exp_diff;
        logic         exp_borrow;
        logic         exp_ovf;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv);
        @(negedge clk);
        a = av;
        b = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
    endtask

    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                cyc = i;
                break;
            end
        end
    endtask

    initial begin
        vec_t vecs[9];
        int   cyc;
        int   pulses;
        int   first_cyc;
        logic [W-1:0] seen_diff;
        logic seen_borrow;

        vecs[0] = '{8'd100, 8'd37,  8'd63,  1'b0, 1'b0};
        vecs[1] = '{8'd5,   8'd9,   8'd252, 1'b1, 1'b0};
        vecs[2] = '{8'hFF,  8'hFF,  8'h00,  1'b0, 1'b0};
        vecs[3] = '{8'h80,  8'h01,  8'h7F,  1'b0, 1'b1};
        vecs[4] = '{8'h10,  8'h01,  8'h0F,  1'b0, 1'b0};
        vecs[5] = '{8'h00,  8'h01,  8'hFF,  1'b1, 1'b0};
        vecs[6] = '{8'h7F,  8'hFF,  8'h80,  1'b1, 1'b1};
        vecs[7] = '{8'hFF,  8'h00,  8'hFF,  1'b0, 1'b0};
        vecs[8] = '{8'hAA,  8'h55,  8'h55,  1'b0, 1'b1};

        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset diff", 32'(diff), 32'd0);
        check("reset borrow", 32'(borrow_out), 32'd0);
`ifdef SERIAL_SUB_SIGNED_EN
        check("reset ovf", 32'(ovf), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            start_op(vecs[i].va, vecs[i].vb);
            check($sformatf("v%0d busy after start", i), 32'(busy), 32'd1);
            check($sformatf("v%0d done after start", i), 32'(done), 32'd0);
            wait_done(cyc);
            check($sformatf("v%0d latency", i), 32'(cyc), 32'(W));
            check($sformatf("v%0d busy at done", i), 32'(busy), 32'd0);
            check($sformatf("v%0d diff", i), 32'(diff), 32'(vecs[i].exp_diff));
            check($sformatf("v%0d borrow", i), 32'(borrow_out), 32'(vecs[i].exp_borrow));
`ifdef SERIAL_SUB_SIGNED_EN
            check($sformatf("v%0d ovf", i), 32'(ovf), 32'(vecs[i].exp_ovf));
`endif
            @(posedge clk);
            #1;
            check($sformatf("v%0d done drop", i), 32'(done), 32'd0);
            check($sformatf("v%0d diff hold", i), 32'(diff), 32'(vecs[i].exp_diff));
        end

        // start re-pulsed mid-operation with other operands must be ignored
        start_op(8'd100, 8'd37);
        repeat (2) @(posedge clk);
        @(negedge clk);
        a = 8'd5;
        b = 8'd9;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("ignore busy", 32'(busy), 32'd1);
        pulses = 0;
        first_cyc = -1;
        seen_diff = '0;
        seen_borrow = 1'b0;
        for (int i = 4; i <= 14; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                pulses++;
                if (first_cyc < 0) begin
                    first_cyc = i;
                    seen_diff = diff;
                    seen_borrow = borrow_out;
                end
            end
        end
        check("ignore pulses", 32'(pulses), 32'd1);
        check("ignore latency", 32'(first_cyc), 32'(W));
        check("ignore diff", 32'(seen_diff), 32'd63);
        check("ignore borrow", 32'(seen_borrow), 32'd0);

        // back-to-back: start held during done
        start_op(8'd200, 8'd100);
        wait_done(cyc);
        check("b2b first latency", 32'(cyc), 32'(W));
        check("b2b first diff", 32'(diff), 32'd100);
        @(negedge clk);
        a = 8'd20;
        b = 8'd21;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b no idle busy", 32'(busy), 32'd1);
        check("b2b no idle done", 32'(done), 32'd0);
        wait_done(cyc);
        check("b2b second latency", 32'(cyc), 32'(W));
        check("b2b second diff", 32'(diff), 32'd255);
        check("b2b second borrow", 32'(borrow_out), 32'd1);

        // asynchronous reset mid-operation
        start_op(8'd5, 8'd9);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst diff", 32'(diff), 32'd0);
        check("rst borrow", 32'(borrow_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("rst no done", 32'(pulses), 32'd0);
        check("rst idle busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
